// File: rtl/ifetch_pq.sv
// ifetch_pq
//   Instruction-fetch stage with a DEPTH-entry prefetch queue. It streams
//   sequential reads from a synchronous instruction memory that answers one
//   cycle after each request. Results are buffered so fetch keeps running
//   while decode stalls. A branch flushes the queue and drops the in-flight
//   read. An empty queue presents NOP_INST to decode.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   branch_i       redirect fetch to branch_addr_i and flush (highest priority)
//   branch_addr_i  redirect target
//   stall_i        decode is not accepting; the head entry is held
//   imem_req_o     read request this cycle
//   imem_addr_o    read address (current pc)
//   imem_rdata_i   read data, valid the cycle after imem_req_o
//   inst_o         head instruction, or NOP_INST when the queue is empty
//   inst_addr_o    head address, or 0 when the queue is empty
//   inst_valid_o   queue is non-empty
//   q_count_o      number of occupied queue entries
module ifetch_pq #(
    parameter int unsigned      ADDR     = 16,
    parameter int unsigned      WORD     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WORD-1:0]  NOP_INST = 32'h3C00_0000,
    parameter logic [ADDR-1:0]  RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     branch_i,
    input  logic [ADDR-1:0]          branch_addr_i,
    input  logic                     stall_i,
    output logic                     imem_req_o,
    output logic [ADDR-1:0]          imem_addr_o,
    input  logic [WORD-1:0]          imem_rdata_i,
    output logic [WORD-1:0]          inst_o,
    output logic [ADDR-1:0]          inst_addr_o,
    output logic                     inst_valid_o,
    output logic [$clog2(DEPTH):0]   q_count_o
);

    localparam int unsigned    PTR_W   = $clog2(DEPTH);
    localparam int unsigned    CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [ADDR-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             inflight_q, inflight_d;
    logic [ADDR-1:0]  inflight_addr_q, inflight_addr_d;
    logic [WORD-1:0]  data_q [DEPTH];
    logic [WORD-1:0]  data_d [DEPTH];
    logic [ADDR-1:0]  addr_q [DEPTH];
    logic [ADDR-1:0]  addr_d [DEPTH];

    logic [CNT_W:0]   credit;
    logic             req;
    logic             write_en;
    logic             pop;

    // Credit counts the read already in flight, so a request is only issued
    // when its response is guaranteed a free slot. The queue can never overflow.
    always_comb begin
        credit   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        req      = rst & ~branch_i & (credit < DEPTH_C);
        write_en = inflight_q & ~branch_i;
        pop      = (count_q != '0) & ~stall_i & ~branch_i;
    end

    always_comb begin
        pc_d            = pc_q;
        count_d         = count_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        inflight_d      = 1'b0;
        inflight_addr_d = inflight_addr_q;
        data_d          = data_q;
        addr_d          = addr_q;

        if (branch_i) begin
            // Flush: the response for the old in-flight read is dropped.
            pc_d     = branch_addr_i;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (req) begin
                pc_d            = pc_q + ADDR'(1);
                inflight_d      = 1'b1;
                inflight_addr_d = pc_q;
            end
            if (write_en) begin
                data_d[wr_ptr_q] = imem_rdata_i;
                addr_d[wr_ptr_q] = inflight_addr_q;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({write_en, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q            <= RESET_PC;
            count_q         <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            pc_q            <= pc_d;
            count_q         <= count_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            data_q          <= data_d;
            addr_q          <= addr_d;
        end
    end

    always_comb begin
        imem_req_o   = req;
        imem_addr_o  = pc_q;
        inst_valid_o = (count_q != '0);
        inst_o       = inst_valid_o ? data_q[rd_ptr_q] : NOP_INST;
        inst_addr_o  = inst_valid_o ? addr_q[rd_ptr_q] : '0;
        q_count_o    = count_q;
    end

endmodule

// File: tb/tb_ifetch_pq.sv
// tb_ifetch_pq
//   Directed bench for ifetch_pq with default parameters (DEPTH=4).
//   The instruction memory holds mem[i] = i and answers one cycle after
//   each request. Inputs change 1 time unit after the rising edge and
//   outputs are checked 2 time units after the rising edge.
module tb_ifetch_pq;

    localparam logic [31:0] NOP = 32'h3C00_0000;

    logic        clk;
    logic        rst;
    logic        branch_i;
    logic [15:0] branch_addr_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o;
    logic [15:0] inst_addr_o;
    logic        inst_valid_o;
    logic [2:0]  q_count_o;

    int testsRun    = 0;
    int testsFailed = 0;

    ifetch_pq dut (
        .clk           (clk),
        .rst           (rst),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .stall_i       (stall_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_valid_o  (inst_valid_o),
        .q_count_o     (q_count_o)
    );

    // Clock with a 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous memory model: mem[i] = i, data returned one cycle after the request.
    initial imem_rdata_i = '0;
    always @(posedge clk) begin
        if (imem_req_o) imem_rdata_i <= 32'(imem_addr_o);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic br, input logic [15:0] br_addr, input logic st);
        branch_i      = br;
        branch_addr_i = br_addr;
        stall_i       = st;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkHead(input string tag, input logic [15:0] addr);
        checkOutput({tag, "_valid"}, 32'(inst_valid_o), 32'd1);
        checkOutput({tag, "_addr"}, 32'(inst_addr_o), 32'(addr));
        checkOutput({tag, "_inst"}, inst_o, 32'(addr));
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0);
        #1;
        // Reset values.
        checkOutput("rst_req", 32'(imem_req_o), 32'd0);
        checkOutput("rst_valid", 32'(inst_valid_o), 32'd0);
        checkOutput("rst_inst", inst_o, NOP);
        checkOutput("rst_iaddr", 32'(inst_addr_o), 32'd0);
        checkOutput("rst_count", 32'(q_count_o), 32'd0);

        // Test 1: release reset and stream sequential fetches.
        repeat (2) nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("t1_req0", 32'(imem_req_o), 32'd1);
        checkOutput("t1_raddr0", 32'(imem_addr_o), 32'd0);
        checkOutput("t1_valid0", 32'(inst_valid_o), 32'd0);
        nextCycle(); #1;
        checkOutput("t1_valid1", 32'(inst_valid_o), 32'd0);
        checkOutput("t1_raddr1", 32'(imem_addr_o), 32'd1);
        nextCycle(); #1;
        checkHead("t1_first", 16'd0);
        checkOutput("t1_count", 32'(q_count_o), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            nextCycle(); #1;
            checkHead("t1_stream", 16'(k));
            checkOutput("t1_scount", 32'(q_count_o), 32'd1);
        end

        // Test 2: stall with head 5; queue fills to DEPTH and requests stop.
        applyStimulus(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            nextCycle(); #1;
            checkOutput("t2_hold_addr", 32'(inst_addr_o), 32'd5);
            checkOutput("t2_hold_inst", inst_o, 32'd5);
        end
        checkOutput("t2_full", 32'(q_count_o), 32'd4);
        checkOutput("t2_noreq", 32'(imem_req_o), 32'd0);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        for (int j = 0; j < 5; j++) begin
            checkHead("t2_drain", 16'(5 + j));
            nextCycle(); #1;
        end
        checkHead("t2_resume", 16'd10);
        checkOutput("t2_count", 32'(q_count_o), 32'd2);

        // Test 3: branch while 3 entries are queued and a fetch is in flight.
        applyStimulus(1'b0, 16'h0000, 1'b1);
        nextCycle(); #1;
        checkOutput("t3_pre_count", 32'(q_count_o), 32'd3);
        checkOutput("t3_pre_noreq", 32'(imem_req_o), 32'd0);
        applyStimulus(1'b1, 16'h0100, 1'b0);
        checkOutput("t3_br_noreq", 32'(imem_req_o), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkOutput("t3_count0", 32'(q_count_o), 32'd0);
        checkOutput("t3_valid0", 32'(inst_valid_o), 32'd0);
        checkOutput("t3_nop", inst_o, NOP);
        checkOutput("t3_iaddr0", 32'(inst_addr_o), 32'd0);
        checkOutput("t3_req", 32'(imem_req_o), 32'd1);
        checkOutput("t3_raddr", 32'(imem_addr_o), 32'h0100);
        nextCycle(); #1;
        checkOutput("t3_valid2", 32'(inst_valid_o), 32'd0);
        nextCycle(); #1;
        checkHead("t3_target", 16'h0100);
        nextCycle(); #1;
        checkHead("t3_next", 16'h0101);

        // Test 4: branch near the top of the address space; pc wraps.
        applyStimulus(1'b1, 16'hFFFE, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkOutput("t4_raddr0", 32'(imem_addr_o), 32'hFFFE);
        nextCycle(); #1;
        checkOutput("t4_raddr1", 32'(imem_addr_o), 32'hFFFF);
        nextCycle(); #1;
        checkHead("t4_h0", 16'hFFFE);
        checkOutput("t4_raddr2", 32'(imem_addr_o), 32'h0000);
        nextCycle(); #1;
        checkHead("t4_h1", 16'hFFFF);
        nextCycle(); #1;
        checkHead("t4_h2", 16'h0000);
        nextCycle(); #1;
        checkHead("t4_h3", 16'h0001);

        // Test 5: branch and stall together; branch wins.
        applyStimulus(1'b1, 16'h0200, 1'b1);
        checkOutput("t5_br_noreq", 32'(imem_req_o), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkOutput("t5_count0", 32'(q_count_o), 32'd0);
        checkOutput("t5_valid0", 32'(inst_valid_o), 32'd0);
        checkOutput("t5_raddr", 32'(imem_addr_o), 32'h0200);
        nextCycle(); #1;
        nextCycle(); #1;
        checkHead("t5_target", 16'h0200);
        checkOutput("t5_count1", 32'(q_count_o), 32'd1);

        // Test 6: asynchronous reset while full and stalled.
        applyStimulus(1'b0, 16'h0000, 1'b1);
        repeat (6) nextCycle();
        #1;
        checkOutput("t6_full", 32'(q_count_o), 32'd4);
        checkHead("t6_head", 16'h0200);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_req", 32'(imem_req_o), 32'd0);
        checkOutput("t6_valid", 32'(inst_valid_o), 32'd0);
        checkOutput("t6_inst", inst_o, NOP);
        checkOutput("t6_iaddr", 32'(inst_addr_o), 32'd0);
        checkOutput("t6_count", 32'(q_count_o), 32'd0);
        stall_i = 1'b0;
        repeat (2) nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("t6_rel_req", 32'(imem_req_o), 32'd1);
        checkOutput("t6_rel_raddr", 32'(imem_addr_o), 32'd0);
        nextCycle(); #1;
        checkOutput("t6_rel_valid", 32'(inst_valid_o), 32'd0);
        nextCycle(); #1;
        checkHead("t6_restart", 16'h0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
